// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states and flag layout.
package alu_pkg;

    typedef enum logic [3:0] {
        F_SUM = 4'd0,
        F_SUB = 4'd1,
        F_AND = 4'd2,
        F_OR  = 4'd3,
        F_NOT = 4'd4,
        F_LSL = 4'd5,
        F_LSR = 4'd6,
        F_ADC = 4'd7,
        F_MUL = 4'd8,
        F_CMP = 4'd9
    } func_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_P = 4;

    typedef struct packed {
        logic [2:0] rsvd;
        logic       parity;
        logic       zero;
        logic       overflow;
        logic       negative;
        logic       carry;
    } flags_t;

    // Place individual flag bits at their architectural indices.
    function automatic flags_t make_flags(input logic p, input logic z, input logic v,
                                          input logic n, input logic c);
        logic [7:0] f;
        f         = '0;
        f[FLAG_P] = p;
        f[FLAG_Z] = z;
        f[FLAG_V] = v;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        return flags_t'(f);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: bit 0 is folded in at start, the remaining
// WIDTH-1 bits on the following edges; done pulses once the full product is held.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                product  <= b[0] ? PW'(a) : '0;
                mcand_q  <= PW'(a) << 1;
                mplier_q <= b >> 1;
                cnt_q    <= CNT_W'(1);
                busy_q   <= 1'b1;
            end else if (busy_q) begin
                if (mplier_q[0]) begin
                    product <= product + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    busy_q <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes; single-cycle ops complete at accept,
// MUL runs through the iterative multiplier. Result, flags and err are registered.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [7:0]       flags,
    output logic             err
);

    localparam int unsigned EW = WIDTH + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q;
    flags_t           flags_q;
    logic             err_q, out_valid_q, in_ready_q;

    logic             accept_c, mul_start_c, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]   sum_c, diff_c, shl_c, shr_c;
    logic             cin_c, add_ovf_c, sub_ovf_c;
    logic [WIDTH-1:0] res_c, fsrc_c;
    logic             carry_c, ovf_c, legal_c;
    flags_t           flg_c, mul_flg_c;

    assign accept_c    = (state_q == S_IDLE) && in_valid;
    assign mul_start_c = accept_c && (func == F_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start_c),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = (func == F_MUL) ? S_MUL : S_DONE;
            S_MUL:   if (mul_done)  state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Carry-in only feeds ADC; shifts use one extra bit to catch the last bit shifted out.
    assign cin_c     = (func == F_ADC) && flags_q.carry;
    assign sum_c     = {1'b0, a} + {1'b0, b} + EW'(cin_c);
    assign diff_c    = {1'b0, a} - {1'b0, b};
    assign shl_c     = {1'b0, a} << b;
    assign shr_c     = {a, 1'b0} >> b;
    assign add_ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        legal_c = 1'b1;
        case (func)
            F_SUM, F_ADC: begin
                res_c   = sum_c[WIDTH-1:0];
                carry_c = sum_c[WIDTH];
                ovf_c   = add_ovf_c;
            end
            F_SUB, F_CMP: begin
                res_c   = (func == F_CMP) ? a : diff_c[WIDTH-1:0];
                carry_c = diff_c[WIDTH];
                ovf_c   = sub_ovf_c;
            end
            F_AND:   res_c = a & b;
            F_OR:    res_c = a | b;
            F_NOT:   res_c = ~a;
            F_LSL: begin
                res_c   = shl_c[WIDTH-1:0];
                carry_c = shl_c[WIDTH];
            end
            F_LSR: begin
                res_c   = shr_c[WIDTH:1];
                carry_c = shr_c[0];
            end
            F_MUL:   legal_c = 1'b1;
            default: legal_c = 1'b0;
        endcase
        // CMP reports the flags of the difference while passing a through.
        fsrc_c = (func == F_CMP) ? diff_c[WIDTH-1:0] : res_c;
        flg_c  = make_flags(~^fsrc_c, fsrc_c == '0, ovf_c, fsrc_c[WIDTH-1], carry_c);
        if (!legal_c) begin
            res_c = '0;
            flg_c = flags_q;
        end
    end

    always_comb begin
        mul_flg_c = make_flags(~^mul_prod[WIDTH-1:0], mul_prod[WIDTH-1:0] == '0, 1'b0,
                               mul_prod[WIDTH-1], |mul_prod[2*WIDTH-1:WIDTH]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            out_valid_q <= (state_d == S_DONE);
            in_ready_q  <= (state_d == S_IDLE);
            if (accept_c && (func != F_MUL)) begin
                out_q   <= res_c;
                flags_q <= flg_c;
                err_q   <= ~legal_c;
            end else if ((state_q == S_MUL) && mul_done) begin
                out_q   <= mul_prod[WIDTH-1:0];
                flags_q <= mul_flg_c;
                err_q   <= 1'b0;
            end
        end
    end

    assign out       = out_q;
    assign flags     = flags_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8 with hand-computed expectations.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] func;
    logic [7:0] a, b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [7:0] flags;
    logic       err;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func      (func),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge; returns 1ns after the accept edge.
    task automatic issue(input logic [3:0] f, input logic [7:0] av, input logic [7:0] bv);
        func     = f;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ov_low"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        func      = 4'd0;
        a         = 8'd0;
        b         = 8'd0;
        #12;
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_rdy", 32'(in_ready), 32'd1);

        // SUM with signed overflow
        issue(4'd0, 8'h7F, 8'h01);
        check("sum_ov", 32'(out_valid), 32'd1);
        check("sum_out", 32'(out), 32'h80);
        check("sum_flags", 32'(flags), 32'h06);
        check("sum_err", 32'(err), 32'd0);
        check("sum_busy", 32'(in_ready), 32'd0);
        retire("sum");

        // SUB borrow then ADC consuming it
        issue(4'd1, 8'h00, 8'h01);
        check("sub_out", 32'(out), 32'hFF);
        check("sub_flags", 32'(flags), 32'h13);
        retire("sub");
        issue(4'd7, 8'h01, 8'h01);
        check("adc_out", 32'(out), 32'h03);
        check("adc_flags", 32'(flags), 32'h10);
        retire("adc");

        // NOT
        issue(4'd4, 8'h0F, 8'h00);
        check("not_out", 32'(out), 32'hF0);
        check("not_flags", 32'(flags), 32'h12);
        retire("not");

        // MUL with ignored in_valid pulses while busy
        issue(4'd8, 8'h10, 8'h10);
        check("mul_ov_c1", 32'(out_valid), 32'd0);
        func     = 4'd0;
        a        = 8'h01;
        b        = 8'h01;
        in_valid = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            @(posedge clk); #1;
            check($sformatf("mul_ov_c%0d", i), 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        check("mul_ov_c9", 32'(out_valid), 32'd1);
        check("mul_out", 32'(out), 32'h00);
        check("mul_flags", 32'(flags), 32'h19);
        check("mul_err", 32'(err), 32'd0);

        // Back-pressure in DONE with in_valid still asserted
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold_ov_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("hold_out_%0d", i), 32'(out), 32'h00);
            check($sformatf("hold_flags_%0d", i), 32'(flags), 32'h19);
            check($sformatf("hold_rdy_%0d", i), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        retire("mul");

        // Illegal func keeps previous flags
        issue(4'd12, 8'h55, 8'h33);
        check("ill_err", 32'(err), 32'd1);
        check("ill_out", 32'(out), 32'h00);
        check("ill_flags", 32'(flags), 32'h19);
        retire("ill");

        // Shifts, with an illegal op between to show out is cleared
        issue(4'd5, 8'h81, 8'd1);
        check("lsl_out", 32'(out), 32'h02);
        check("lsl_flags", 32'(flags), 32'h01);
        check("lsl_err", 32'(err), 32'd0);
        retire("lsl");
        issue(4'd15, 8'h81, 8'd1);
        check("ill2_out", 32'(out), 32'h00);
        check("ill2_flags", 32'(flags), 32'h01);
        check("ill2_err", 32'(err), 32'd1);
        retire("ill2");
        issue(4'd6, 8'h81, 8'd9);
        check("lsr_out", 32'(out), 32'h00);
        check("lsr_flags", 32'(flags), 32'h18);
        check("lsr_err", 32'(err), 32'd0);
        retire("lsr");
        issue(4'd6, 8'h81, 8'd8);
        check("lsr8_out", 32'(out), 32'h00);
        check("lsr8_flags", 32'(flags), 32'h19);
        retire("lsr8");

        // Reset in the middle of a MUL
        issue(4'd8, 8'h03, 8'h05);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_ov", 32'(out_valid), 32'd0);
        check("abort_out", 32'(out), 32'd0);
        check("abort_flags", 32'(flags), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_rdy", 32'(in_ready), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_result", 32'(out_valid), 32'd0);
        issue(4'd0, 8'h02, 8'h03);
        check("post_ov", 32'(out_valid), 32'd1);
        check("post_out", 32'(out), 32'h05);
        check("post_flags", 32'(flags), 32'h10);
        retire("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
